data_memory_bx: RTL and testbench
=================================

DATA_MEMORY_BX -- requirements
Module: data_memory_bx

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 Parameter ADDR_WIDTH, default 32, SHALL be the request byte-address width.
REQ-003 Parameter DEPTH_WORDS, default 1024, SHALL be the number of 32-bit words; it SHALL be a power of two and at least 2.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  block accepts a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_addr  input  ADDR_WIDTH  byte address.
REQ-010 req_funct3  input  3  RV32I size code: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
REQ-011 req_wdata  input  32  store data, right-aligned.
REQ-012 rsp_valid  output  1  one-cycle response strobe.
REQ-013 rsp_rdata  output  32  load result, extended per funct3.
REQ-014 rsp_err  output  1  request rejected; qualified by rsp_valid.

Function
REQ-015 The FSM SHALL have two states, INIT and RUN. INIT SHALL write zero to word 0..DEPTH_WORDS-1, one word per cycle, then move to RUN. req_ready SHALL be 0 in INIT and 1 in RUN.
REQ-016 A request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1. One request SHALL be accepted per cycle, with no backpressure on responses.
REQ-017 The word index SHALL be req_addr[log2(DEPTH_WORDS)+1:2]. Higher address bits SHALL be ignored, so addresses wrap modulo 4*DEPTH_WORDS.
REQ-018 Stores SHALL write on the accepting edge:
- SB writes byte lane addr[1:0] with wdata[7:0].
- SH writes lanes {addr[1],0} and {addr[1],1} with wdata[15:0].
- SW writes all lanes.
- Other lanes SHALL be preserved.
REQ-019 Loads SHALL select the lane as in REQ-018:
- B/H sign-extend.
- BU/HU zero-extend.
- W returns the full word.
REQ-020 rsp_valid SHALL assert exactly one cycle after every accepted request, load or store. For stores, rsp_rdata SHALL be 0.
REQ-021 A load accepted the cycle after a store to the same word SHALL return the updated data.
REQ-022 Invalid funct3 SHALL produce rsp_valid=1, rsp_err=1 and rsp_rdata=0, with no memory write. Invalid codes are 3, 6 and 7 for loads, and 3 to 7 for stores.
REQ-023 When rsp_valid=0, rsp_rdata and rsp_err SHALL be 0.

Reset
REQ-024 While rst_n=0, the outputs SHALL be req_ready=0, rsp_valid=0, rsp_rdata=0 and rsp_err=0. The FSM SHALL be in INIT with the clear counter at 0.
REQ-025 Reset asserted mid-INIT or mid-RUN SHALL take effect immediately and SHALL drop any pending response. After release, clearing SHALL restart from word 0, taking DEPTH_WORDS cycles before req_ready rises.

Configuration
REQ-026 Macro DATA_MEMORY_BX_MISALIGN_TRAP_EN, when defined, SHALL make misaligned requests return rsp_err=1 and rsp_rdata=0 with no write. Misaligned means H/HU with addr[0]=1, or W with addr[1:0]!=0.
REQ-027 When DATA_MEMORY_BX_MISALIGN_TRAP_EN is undefined, misalignment SHALL NOT raise rsp_err. H/HU SHALL ignore addr[0], and W SHALL ignore addr[1:0].

Verification
REQ-028 Reset release with DEPTH_WORDS=16: req_ready SHALL be low for exactly 16 cycles. A subsequent LW from 0x3C SHALL return 0x00000000.
REQ-029 SW 0x8000_00FF at 0x10, then LB/LBU 0x10, then LH/LHU 0x12: the loads SHALL return 0xFFFFFFFF, 0x000000FF, 0xFFFF8000 and 0x00008000.
REQ-030 SW 0x11223344 at 0x20, then SB 0xAA at 0x21, then LW 0x20 on the next cycle: the load SHALL return 0x1122AA44. rsp_valid SHALL be seen on each of the 3 consecutive cycles after each acceptance.
REQ-031 Load with funct3=3 and store with funct3=4: each SHALL give rsp_err=1 and rsp_rdata=0. The memory word SHALL be unchanged.
REQ-032 LW at 0x22 with the macro defined SHALL give rsp_err=1. Without the macro it SHALL return the word at 0x20 with rsp_err=0.
REQ-033 rst_n pulsed low on the cycle after a load is accepted: no rsp_valid SHALL appear. req_ready SHALL return only after DEPTH_WORDS cycles, and the memory SHALL read back as zero.

Source files
------------

// File: rtl/data_memory_bx.sv
// Byte-addressable RV32I data memory, self-clearing after reset.
// Define DATA_MEMORY_BX_MISALIGN_TRAP_EN to reject misaligned H/W.
module data_memory_bx #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_funct3,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int IW = $clog2(DEPTH_WORDS);

  typedef enum logic {INIT, RUN} state_t;

  state_t        state_q, state_d;
  logic [IW-1:0] cnt_q, cnt_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [31:0]   rsp_rdata_q, rsp_rdata_d;
  logic          rsp_err_q, rsp_err_d;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic [IW-1:0] idx, wr_idx;
  logic [3:0]    wr_be;
  logic [31:0]   wr_data;
  logic          wr_en;
  logic [1:0]    lane;
  logic          is_b, is_h;
  logic          bad_f3, misal, acc;
  logic [31:0]   rd_word;
  logic [7:0]    ld_b;
  logic [15:0]   ld_h;
  logic          unused_addr;

  assign idx         = req_addr[IW+1:2];
  assign lane        = req_addr[1:0];
  assign unused_addr = ^req_addr[ADDR_WIDTH-1:IW+2];
  assign rd_word     = mem_q[idx];
  assign is_b        = (req_funct3[1:0] == 2'd0);
  assign is_h        = (req_funct3[1:0] == 2'd1);
  assign req_ready   = (state_q == RUN);
  assign acc         = req_valid & req_ready;

  assign bad_f3 = req_we ? (req_funct3 > 3'd2)
                         : ((req_funct3[1:0] == 2'd3) |
                            (req_funct3 == 3'd6));

`ifdef DATA_MEMORY_BX_MISALIGN_TRAP_EN
  assign misal = (is_h & lane[0]) |
                 ((req_funct3 == 3'd2) & (|lane));
`else
  assign misal = 1'b0;
`endif

  assign ld_b = rd_word[{lane, 3'b000} +: 8];
  assign ld_h = rd_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wr_en       = 1'b0;
    wr_idx      = cnt_q;
    wr_be       = 4'hF;
    wr_data     = '0;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = '0;
    rsp_err_d   = 1'b0;
    unique case (state_q)
      INIT: begin
        wr_en = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IW'(DEPTH_WORDS - 1))
          state_d = RUN;
      end
      RUN: begin
        if (acc) begin
          rsp_valid_d = 1'b1;
          if (bad_f3 | misal) begin
            rsp_err_d = 1'b1;
          end else if (req_we) begin
            wr_en  = 1'b1;
            wr_idx = idx;
            // data is replicated so the byte enables pick the lane
            unique case (1'b1)
              is_b: begin
                wr_be   = 4'b0001 << lane;
                wr_data = {4{req_wdata[7:0]}};
              end
              is_h: begin
                wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata[15:0]}};
              end
              default: begin
                wr_be   = 4'hF;
                wr_data = req_wdata;
              end
            endcase
          end else begin
            unique case (1'b1)
              is_b: rsp_rdata_d = req_funct3[2]
                    ? {24'b0, ld_b}
                    : {{24{ld_b[7]}}, ld_b};
              is_h: rsp_rdata_d = req_funct3[2]
                    ? {16'b0, ld_h}
                    : {{16{ld_h[15]}}, ld_h};
              default: rsp_rdata_d = rd_word;
            endcase
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i])
          mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_data_memory_bx.sv
// Self-checking bench for data_memory_bx with DEPTH_WORDS=16,
// using a byte-array reference model and random traffic.
module tb_data_memory_bx;

  localparam int DW = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [2:0]  req_funct3 = '0;
  logic [31:0] req_wdata = '0;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int errors = 0;
  int checks = 0;

  byte unsigned mb [4*DW];

  always #5 clk = ~clk;

  data_memory_bx #(
    .ADDR_WIDTH (32),
    .DEPTH_WORDS(DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_funct3(req_funct3),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  function automatic void mdl_clear();
    foreach (mb[i]) mb[i] = 8'h00;
  endfunction

  // Reference: memory as a flat byte array, access by size/alignment.
  function automatic void mdl(input bit we, input logic [31:0] a,
                              input logic [2:0] f3,
                              input logic [31:0] wd,
                              output logic [31:0] rd,
                              output bit err);
    int sz;
    int am;
    int base;
    bit uns;
    logic [31:0] v;
    rd  = '0;
    err = 1'b0;
    uns = f3[2];
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    if (we && f3 > 3'd2) sz = 0;
    am = int'(a % (4*DW));
`ifdef DATA_MEMORY_BX_MISALIGN_TRAP_EN
    if (sz > 0 && (am % sz) != 0) sz = 0;
`endif
    if (sz == 0) begin
      err = 1'b1;
      return;
    end
    base = am - (am % sz);
    if (we) begin
      for (int i = 0; i < sz; i++) mb[base+i] = wd[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[base+i];
      if (!uns && sz < 4 && v[8*sz-1])
        v = v | (32'hFFFF_FFFF << (8*sz));
      rd = v;
    end
  endfunction

  // Drives one request at a negedge; returns at the next negedge,
  // when its response is visible.
  task automatic send(input bit we, input logic [31:0] a,
                      input logic [2:0] f3, input logic [31:0] wd,
                      output logic [31:0] er, output bit ee);
    mdl(we, a, f3, wd, er, ee);
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = a;
    req_funct3 = f3;
    req_wdata  = wd;
    @(negedge clk);
    req_valid  = 1'b0;
    req_we     = 1'b0;
  endtask

  task automatic wait_ready(output int lows, output bit saw_v);
    lows  = 0;
    saw_v = 1'b0;
    while (req_ready !== 1'b1 && lows < 4*DW) begin
      if (rsp_valid !== 1'b0) saw_v = 1'b1;
      lows++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready got=%b want=0", req_ready);
    end
    checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_rsp got v=%b e=%b want 0 0",
               rsp_valid, rsp_err);
    end
    checks++;
    if (rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata got=%h want=0", rsp_rdata);
    end
  endtask

  task automatic test_init();
    int lows;
    bit sv;
    logic [31:0] er;
    bit ee;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b0) begin
      errors++;
      $display("FAIL midinit_ready got=%b want=0", req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mdl_clear();
    wait_ready(lows, sv);
    checks++;
    if (lows != DW || sv) begin
      errors++;
      $display("FAIL init_cycles got=%0d v=%b want=%0d v=0",
               lows, sv, DW);
    end
    send(1'b0, 32'h3C, 3'd2, 32'h0, er, ee);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 ||
        rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL init_lw3c got v=%b e=%b d=%h want 1 0 0",
               rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_sign_ext();
    logic [31:0] er;
    bit ee;
    logic [31:0] want [4];
    logic [2:0]  f3s  [4];
    logic [31:0] ads  [4];
    want = '{32'hFFFF_FFFF, 32'h0000_00FF,
             32'hFFFF_8000, 32'h0000_8000};
    f3s  = '{3'd0, 3'd4, 3'd1, 3'd5};
    ads  = '{32'h10, 32'h10, 32'h12, 32'h12};
    send(1'b1, 32'h10, 3'd2, 32'h8000_00FF, er, ee);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL sw_rsp got v=%b d=%h want 1 0",
               rsp_valid, rsp_rdata);
    end
    for (int i = 0; i < 4; i++) begin
      send(1'b0, ads[i], f3s[i], 32'h0, er, ee);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 ||
          rsp_rdata !== want[i]) begin
        errors++;
        $display("FAIL sign_ld%0d got v=%b e=%b d=%h want d=%h",
                 i, rsp_valid, rsp_err, rsp_rdata, want[i]);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] er;
    bit ee;
    send(1'b1, 32'h20, 3'd2, 32'h1122_3344, er, ee);
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_sw got v=%b want 1", rsp_valid);
    end
    send(1'b1, 32'h21, 3'd0, 32'h0000_00AA, er, ee);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL b2b_sb got v=%b d=%h want 1 0",
               rsp_valid, rsp_rdata);
    end
    send(1'b0, 32'h20, 3'd2, 32'h0, er, ee);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1122_AA44) begin
      errors++;
      $display("FAIL b2b_lw got v=%b d=%h want 1 1122aa44",
               rsp_valid, rsp_rdata);
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
        rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL idle_rsp got v=%b e=%b d=%h want 0 0 0",
               rsp_valid, rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_invalid();
    logic [31:0] er;
    bit ee;
    send(1'b0, 32'h20, 3'd3, 32'h0, er, ee);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 ||
        rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL bad_ld got v=%b e=%b d=%h want 1 1 0",
               rsp_valid, rsp_err, rsp_rdata);
    end
    send(1'b1, 32'h20, 3'd4, 32'hDEAD_BEEF, er, ee);
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 ||
        rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL bad_st got v=%b e=%b d=%h want 1 1 0",
               rsp_valid, rsp_err, rsp_rdata);
    end
    send(1'b0, 32'h20, 3'd2, 32'h0, er, ee);
    checks++;
    if (rsp_err !== 1'b0 || rsp_rdata !== 32'h1122_AA44) begin
      errors++;
      $display("FAIL bad_st_nowr got e=%b d=%h want 0 1122aa44",
               rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_misalign();
    logic [31:0] er;
    bit ee;
    logic [31:0] wd;
    bit we_err;
`ifdef DATA_MEMORY_BX_MISALIGN_TRAP_EN
    wd = 32'h0;
    we_err = 1'b1;
`else
    wd = 32'h1122_AA44;
    we_err = 1'b0;
`endif
    send(1'b0, 32'h22, 3'd2, 32'h0, er, ee);
    checks++;
    if (rsp_err !== we_err || rsp_rdata !== wd) begin
      errors++;
      $display("FAIL misalign_lw got e=%b d=%h want e=%b d=%h",
               rsp_err, rsp_rdata, we_err, wd);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] er;
    bit ee;
    send(1'b1, 32'hFFFF_FFC4, 3'd2, 32'hCAFE_F00D, er, ee);
    send(1'b0, 32'h0000_0004, 3'd2, 32'h0, er, ee);
    checks++;
    if (rsp_rdata !== 32'hCAFE_F00D || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL wrap got e=%b d=%h want 0 cafef00d",
               rsp_err, rsp_rdata);
    end
  endtask

  task automatic test_random();
    logic [31:0] er;
    bit ee;
    bit we;
    logic [31:0] a;
    logic [2:0] f3;
    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom_range(1));
      a  = $urandom;
      f3 = 3'($urandom_range(7));
      send(we, a, f3, $urandom, er, ee);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_err !== ee ||
          rsp_rdata !== er) begin
        errors++;
        $display("FAIL rand%0d we=%b a=%h f3=%0d got v=%b e=%b d=%h want e=%b d=%h",
                 n, we, a, f3, rsp_valid, rsp_err, rsp_rdata, ee, er);
      end
      if ($urandom_range(3) == 0) begin
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0 ||
            rsp_rdata !== 32'h0) begin
          errors++;
          $display("FAIL rand_idle%0d got v=%b e=%b d=%h want 0",
                   n, rsp_valid, rsp_err, rsp_rdata);
        end
      end
    end
  endtask

  task automatic test_reset_mid_run();
    int lows;
    bit sv;
    logic [31:0] er;
    bit ee;
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_addr   = 32'h20;
    req_funct3 = 3'd2;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    req_valid = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_run got v=%b r=%b want 0 0",
               rsp_valid, req_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    mdl_clear();
    wait_ready(lows, sv);
    checks++;
    if (lows != DW || sv) begin
      errors++;
      $display("FAIL rst_run_init got=%0d v=%b want=%0d v=0",
               lows, sv, DW);
    end
    for (int w = 0; w < DW; w++) begin
      send(1'b0, 32'(w * 4), 3'd2, 32'h0, er, ee);
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0) begin
        errors++;
        $display("FAIL rst_run_zero w%0d got v=%b d=%h want 1 0",
                 w, rsp_valid, rsp_rdata);
      end
    end
  endtask

  initial begin
    mdl_clear();
    test_reset();
    test_init();
    test_sign_ext();
    test_back_to_back();
    test_invalid();
    test_misalign();
    test_wrap();
    test_random();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
